// File: rtl/data_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_pkg
// Brief    : Shared size encodings, FSM state type and default parameters.
// Revision : 1.0
// ============================================================================
package data_memory_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int DEFAULT_DEPTH        = 32;
    localparam int DEFAULT_READ_LATENCY = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/data_memory_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_ctrl_if
// Brief    : Request/response handshake bundle for the data memory controller.
// Revision : 1.0
// ============================================================================
interface data_memory_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );

endinterface
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Brief    : Extracts a byte/half lane from a memory word and sign/zero extends.
// Revision : 1.0
// ============================================================================
module load_align
    import data_memory_pkg::*;
(
    input  wire logic [31:0] i_word,
    input  wire logic [1:0]  i_lane,
    input  wire logic [1:0]  i_size,
    input  wire logic        i_unsigned,
    output logic      [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = 8'(i_word >> {i_lane, 3'b000});
    assign w_half = 16'(i_word >> {i_lane[1], 4'b0000});

    always_comb begin
        o_data = i_word;
        case (i_size)
            SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_ctrl
// Brief    : Byte-addressable word memory with a fixed-latency valid/ready port.
// Revision : 1.0
// ============================================================================
module data_memory_ctrl
    import data_memory_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  wire logic          clock,
    input  wire logic          reset,
    data_memory_ctrl_if.slave  bus
);

    localparam int         c_IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] c_CNT_INIT = 4'(READ_LATENCY - 1);

    logic [31:0]        r_mem [DEPTH];
    state_t             r_state;
    logic [3:0]         r_cnt;
    logic               r_req_ready;
    logic               r_resp_valid;
    logic [31:0]        r_resp_rdata;
    logic               r_resp_error;

    logic [c_IDX_W-1:0] w_idx;
    logic [1:0]         w_lane;
    logic               w_out_of_range;
    logic               w_err;
    logic               w_accept;
    logic               w_store;
    logic [3:0]         w_be;
    logic [31:0]        w_wd;
    logic [31:0]        w_rword;
    logic [31:0]        w_aligned;
    logic [31:0]        w_resp_data;

    assign w_idx          = bus.req_addr[c_IDX_W+1:2];
    assign w_lane         = bus.req_addr[1:0];
    assign w_out_of_range = |bus.req_addr[31:c_IDX_W+2];

    always_comb begin
        w_err = w_out_of_range;
        case (bus.req_size)
            SZ_BYTE: ;
            SZ_HALF: if (w_lane[0])       w_err = 1'b1;
            SZ_WORD: if (w_lane != 2'b00) w_err = 1'b1;
            default: w_err = 1'b1;
        endcase
    end

    // Reset outranks a concurrent request, including its store.
    assign w_accept = bus.req_valid & r_req_ready & ~reset;
    assign w_store  = w_accept & bus.req_write & ~w_err;

    always_comb begin
        w_be = 4'b0000;
        w_wd = bus.req_wdata;
        case (bus.req_size)
            SZ_BYTE: begin
                w_be = 4'b0001 << w_lane;
                w_wd = {4{bus.req_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_be = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wd = {2{bus.req_wdata[15:0]}};
            end
            SZ_WORD: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
            end
        end
    end

    assign w_rword = r_mem[w_idx];

    load_align u_load_align (
        .i_word     (w_rword),
        .i_lane     (w_lane),
        .i_size     (bus.req_size),
        .i_unsigned (bus.req_unsigned),
        .o_data     (w_aligned)
    );

    assign w_resp_data = (w_err | bus.req_write) ? 32'h0 : w_aligned;

    // Response payload is captured at accept so later input changes cannot leak in.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_ready  <= 1'b0;
                        r_resp_rdata <= w_resp_data;
                        r_resp_error <= w_err;
                        if (READ_LATENCY == 1) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= c_CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state      <= ST_RESP;
                        r_cnt        <= 4'd0;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= 32'h0;
                        r_resp_error <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_cnt        <= 4'd0;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_error = r_resp_error;

endmodule
`default_nettype wire

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter DEPTH, default 32, number of 32-bit words; power of two, 2..4096.
REQ-002 Parameter READ_LATENCY, default 1, cycles from request accept to response valid; range 1..8.
REQ-003 Port clock  in  1  single clock; all state updates on posedge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port req_valid  in  1  request present.
REQ-006 Port req_ready  out  1  block can accept a request.
REQ-007 Port req_write  in  1  1 = store, 0 = load.
REQ-008 Port req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 Port req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-010 Port req_addr  in  32  byte address.
REQ-011 Port req_wdata  in  32  store data, right-aligned.
REQ-012 Port resp_valid  out  1  response present.
REQ-013 Port resp_ready  in  1  consumer accepts response.
REQ-014 Port resp_rdata  out  32  load result; 0 for stores and errors.
REQ-015 Port resp_error  out  1  request rejected: misaligned, out of range or reserved size.

Function
REQ-016 Accept occurs on a posedge with req_valid=1 and req_ready=1; at most one request is outstanding.
REQ-017 FSM states: IDLE (req_ready=1), WAIT (latency countdown), RESP (resp_valid=1); req_ready is 1 only in IDLE.
REQ-018 IDLE -> WAIT on accept when READ_LATENCY>1, with counter loaded to READ_LATENCY-1; IDLE -> RESP on accept when READ_LATENCY=1.
REQ-019 WAIT decrements the counter each cycle and moves to RESP when it reaches 1; resp_valid therefore first asserts exactly READ_LATENCY cycles after the accept edge.
REQ-020 RESP holds resp_valid, resp_rdata and resp_error stable until a posedge with resp_ready=1, then returns to IDLE; a new request is accepted no earlier than the cycle after that edge.
REQ-021 Word index = req_addr[log2(DEPTH)+1:2]; lane = req_addr[1:0]; little-endian byte order.
REQ-022 Error when req_size=11, or half with addr[0]=1, or word with addr[1:0]!=0, or req_addr >= 4*DEPTH.
REQ-023 On error, memory is not modified, resp_rdata=0, and resp_error=1 is reported after the normal latency.
REQ-024 A store commits on the accept edge: a byte store writes lane addr[1:0] from wdata[7:0]; a half store writes lanes addr[1]*2 and addr[1]*2+1 from wdata[15:0]; a word store writes all lanes; unaddressed lanes are unchanged.
REQ-025 A store gets a response with resp_rdata=0 and resp_error=0 after the same latency as a load.
REQ-026 A load samples memory at the accept edge, so it sees every store accepted earlier; the selected byte or half is sign- or zero-extended to 32 bits per req_unsigned; a word load ignores req_unsigned.
REQ-027 Request inputs are ignored outside accept edges; changes to them during WAIT or RESP have no effect.

Reset
REQ-028 On a posedge with reset=1: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_error=0; req_ready=1 from the following cycle.
REQ-029 Reset takes priority over accept: a request presented in the reset cycle is not accepted.
REQ-030 Reset in WAIT or RESP drops the pending response; a store already committed stays in memory.
REQ-031 Memory contents are not altered by reset.

Structure
REQ-032 Package data_memory_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum and the default DEPTH and READ_LATENCY constants.
REQ-033 Sub-module load_align (combinational) performs byte/half extraction and sign/zero extension; storage, lane-write logic and FSM live in data_memory_ctrl.

Verification
REQ-034 READ_LATENCY=3: store word 0xDEADBEEF at addr 0x8, then load word 0x8 -> resp_valid exactly 3 cycles after each accept; load returns rdata=0xDEADBEEF, error=0.
REQ-035 After REQ-034: byte store 0x7F at 0x9, then load byte 0x9 signed -> 0x0000007F; half load 0xA signed -> 0xFFFFDEAD; half load 0xA unsigned -> 0x0000DEAD; word 0x8 -> 0xDEAD7FEF.
REQ-036 Half load at 0x3, word load at 0x6, load at 4*DEPTH, req_size=11 -> each gives error=1, rdata=0; a misaligned word store at 0x6 leaves words 1 and 2 unchanged.
REQ-037 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and data stay stable and req_ready=0 throughout; resp_ready=1 -> IDLE next cycle, and a back-to-back request is accepted.
REQ-038 Assert reset in WAIT after store 0x12345678 to 0x0 -> no resp_valid, req_ready=1 after reset; load 0x0 -> 0x12345678.
